instruction_fetch: RTL and testbench
====================================

Name: instruction_fetch

Overview:
Upstream fetch stage for the single-cycle MIPS core in `execution`.
- Owns the program counter and computes the next PC: sequential, branch, jump, or jump-register.
- Drives the instruction-memory address and presents the fetched word to decode/execution.
- Runs a small run/halt/fault state machine so benches can detect the end-of-program "j ." loop and bad jr targets without timing guesses.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset (word aligned)
NOP_WORD, 32'h0000_0000, instruction presented when not in RUN (sll $0,$0,0)

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
stall  input  1  hold PC this cycle; no state change except reset
branch_taken  input  1  conditional branch resolved taken this cycle
branch_offset  input  16  branch immediate, word offset, signed
jump  input  1  j/jal this cycle
jump_target  input  26  j-format target field
jump_reg  input  1  jr this cycle
reg_target  input  32  register value for jr
imem_addr  output  32  instruction memory byte address (combinational read memory)
imem_data  input  32  word returned by instruction memory, same cycle
instr  output  32  instruction to decode
pc  output  32  current PC
pc_plus4  output  32  pc + 4, for jal link
halted  output  1  state == HALT
fetch_fault  output  1  state == FAULT
fetch_count  output  32  retired-fetch counter (see Optional Feature)

Behaviour:
- Reset:
  - Synchronous and dominant over all other inputs.
  - pc <= RESET_PC; state <= RUN; halted = 0; fetch_fault = 0; fetch_count <= 0.
- imem_addr = pc; pc_plus4 = pc + 4. Both combinational, 32-bit wrap (0xFFFF_FFFC + 4 = 0).
- instr = imem_data in RUN, otherwise NOP_WORD.
- next_pc priority: jump_reg > jump > branch_taken > sequential.
  - jr: reg_target.
  - j: {pc_plus4[31:28], jump_target, 2'b00}.
  - branch: pc_plus4 + (sext(branch_offset) << 2), mod 2^32.
  - sequential: pc_plus4.
  - Multiple redirects asserted in one cycle: highest priority wins, no error.
- States: RUN, HALT, FAULT. Encoding is free; halted and fetch_fault are decoded from the state.
- RUN, stall=1: pc, state and fetch_count unchanged.
- RUN, stall=0, jump_reg=1, reg_target[1:0] != 0: state <= FAULT; pc unchanged.
- RUN, stall=0, redirect (jr/j/branch) with next_pc == pc: state <= HALT; pc unchanged. This is the "j ." terminator.
- RUN, stall=0, otherwise: pc <= next_pc.
- HALT and FAULT:
  - Absorbing; left only by reset.
  - pc frozen; all control inputs ignored; instr = NOP_WORD.
- Fault check precedes halt check, e.g. jr to the same misaligned pc → FAULT.
- Sequential fall-through never triggers HALT, even if PC wraps onto itself; that is impossible for +4 anyway.
- Latency: a redirect seen in cycle N is visible on pc/imem_addr in cycle N+1. No bubbles; single-cycle core.
- Reset asserted mid-HALT/FAULT/stall: next edge returns to RUN at RESET_PC.

Optional Feature:
FETCH_PERF_EN
- Defined:
  - fetch_count increments by 1 (mod 2^32) on each edge where state == RUN, stall == 0, and no FAULT/HALT transition occurs, i.e. each PC advance.
  - Cleared by reset.
- Undefined: fetch_count tied to 32'h0; no counter flops synthesized.

Test Plan:
1. Reset, 4 unstalled cycles with no redirects → pc 0x0,0x4,0x8,0xC,0x10; instr tracks imem_data; halted=0.
2. pc=0x10, branch_taken=1, branch_offset=16'hFFFC → next pc 0x04; offset 16'h0003 from 0x04 → 0x14.
3. pc=0x20, jump=1 and branch_taken=1, jump_target=26'h0000040 → pc 0x100 (jump wins). Then jump_target=26'h40 again → HALT: halted=1, pc stays 0x100, instr=0. With FETCH_PERF_EN, fetch_count frozen.
4. pc=0x8, stall=1 for 3 cycles with jump asserted → pc stays 0x8, state RUN. Stall drops → pc = jump target.
5. jump_reg=1, reg_target=0x0000_0102 → fetch_fault=1, pc unchanged, instr=0 for 5 cycles. Reset pulse → pc=RESET_PC, fault=0.
6. With FETCH_PERF_EN: 10 advances, 2 stalls, then "j ." → fetch_count=10. Without FETCH_PERF_EN → fetch_count=0.

Source files
------------

// File: rtl/instruction_fetch.sv
// ---------------------------------------------------------------------------
// instruction_fetch
//   Fetch stage for the single-cycle MIPS core. Holds the program counter,
//   selects the next PC (jr > j > branch > sequential), drives the
//   instruction-memory address and forwards the fetched word to decode.
//   A RUN/HALT/FAULT state machine flags the "j ." end-of-program loop
//   (HALT) and misaligned jr targets (FAULT); both are left only by reset.
//
//   Build option:
//     FETCH_PERF_EN  - when defined, fetch_count counts PC advances;
//                      otherwise fetch_count is tied to zero.
//
//   Ports:
//     clk, reset        rising-edge clock, synchronous active-high reset
//     stall             hold PC and state this cycle
//     branch_taken      taken conditional branch, branch_offset = word offset
//     jump              j/jal, jump_target = 26-bit j-format field
//     jump_reg          jr, reg_target = register target address
//     imem_addr         instruction memory byte address (= pc)
//     imem_data         word returned by instruction memory, same cycle
//     instr             instruction to decode (NOP_WORD unless RUN)
//     pc, pc_plus4      current PC and PC + 4 (link value)
//     halted            state is HALT
//     fetch_fault       state is FAULT
//     fetch_count       PC-advance counter (zero without FETCH_PERF_EN)
// ---------------------------------------------------------------------------
module instruction_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [15:0] branch_offset,
    input  logic        jump,
    input  logic [25:0] jump_target,
    input  logic        jump_reg,
    input  logic [31:0] reg_target,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    output logic [31:0] instr,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        halted,
    output logic        fetch_fault,
    output logic [31:0] fetch_count
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        HALT  = 2'd1,
        FAULT = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] next_pc;
    logic [31:0] branch_target;
    logic [31:0] jump_addr;
    logic        redirect;

    always_comb begin
        pc_plus4      = pc_q + 32'd4;
        branch_target = pc_plus4 + {{14{branch_offset[15]}}, branch_offset, 2'b00};
        jump_addr     = {pc_plus4[31:28], jump_target, 2'b00};
        redirect      = jump_reg | jump | branch_taken;

        if (jump_reg)
            next_pc = reg_target;
        else if (jump)
            next_pc = jump_addr;
        else if (branch_taken)
            next_pc = branch_target;
        else
            next_pc = pc_plus4;
    end

    // Next-state / next-PC. Fault is tested before halt so a misaligned jr
    // can never be mistaken for the "j ." terminator.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        if (state_q == RUN && !stall) begin
            if (jump_reg && reg_target[1:0] != 2'b00)
                state_d = FAULT;
            else if (redirect && next_pc == pc_q)
                state_d = HALT;
            else
                pc_d = next_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RUN;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] fetch_count_q, fetch_count_d;

    // A PC advance is exactly a RUN, unstalled cycle that stays in RUN.
    always_comb begin
        fetch_count_d = fetch_count_q;
        if (state_q == RUN && !stall && state_d == RUN)
            fetch_count_d = fetch_count_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (reset)
            fetch_count_q <= '0;
        else
            fetch_count_q <= fetch_count_d;
    end

    assign fetch_count = fetch_count_q;
`else
    assign fetch_count = '0;
`endif

    assign imem_addr   = pc_q;
    assign pc          = pc_q;
    assign instr       = (state_q == RUN) ? imem_data : NOP_WORD;
    assign halted      = (state_q == HALT);
    assign fetch_fault = (state_q == FAULT);

endmodule

// File: tb/tb_instruction_fetch.sv
// ---------------------------------------------------------------------------
// tb_instruction_fetch
//   Directed bench for instruction_fetch. A behavioural model tracks the
//   architectural PC, run/halt/fault flags and advance count; a negedge
//   process compares every DUT output against it each cycle after reset.
//   Literal PC/flag checks along the way pin the model to hand-derived values.
// ---------------------------------------------------------------------------
module tb_instruction_fetch;

    localparam logic [31:0] RST_PC  = 32'h0000_0000;
    localparam logic [31:0] NOP     = 32'h0000_0000;
    localparam logic [31:0] MEM_KEY = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        reset, stall, branch_taken, jump, jump_reg;
    logic [15:0] branch_offset;
    logic [25:0] jump_target;
    logic [31:0] reg_target;
    logic [31:0] imem_addr, imem_data, instr, pc, pc_plus4, fetch_count;
    logic        halted, fetch_fault;

    int n_pass  = 0;
    int n_total = 0;
    bit checking = 1'b0;

    // Behavioural model state.
    logic [31:0] m_pc;
    bit          m_halt, m_fault;
    logic [31:0] m_cnt;

    instruction_fetch #(.RESET_PC(RST_PC), .NOP_WORD(NOP)) dut (
        .clk(clk), .reset(reset), .stall(stall),
        .branch_taken(branch_taken), .branch_offset(branch_offset),
        .jump(jump), .jump_target(jump_target),
        .jump_reg(jump_reg), .reg_target(reg_target),
        .imem_addr(imem_addr), .imem_data(imem_data), .instr(instr),
        .pc(pc), .pc_plus4(pc_plus4), .halted(halted),
        .fetch_fault(fetch_fault), .fetch_count(fetch_count)
    );

    always #5 clk = ~clk;

    // Combinational instruction memory: a distinct word per address.
    assign imem_data = imem_addr ^ MEM_KEY;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Model: architectural next-PC rules, evaluated once per rising edge.
    always @(posedge clk) begin
        logic [31:0] seq, tgt;
        bit          redir;
        if (reset) begin
            m_pc = RST_PC; m_halt = 0; m_fault = 0; m_cnt = 0;
        end else if (!m_halt && !m_fault && !stall) begin
            seq   = m_pc + 32'd4;
            redir = 1;
            if (jump_reg)          tgt = reg_target;
            else if (jump)         tgt = {seq[31:28], jump_target, 2'b00};
            else if (branch_taken) tgt = seq + 32'(4 * int'($signed(branch_offset)));
            else begin             tgt = seq; redir = 0; end
            if (jump_reg && reg_target[1:0] != 2'b00) m_fault = 1;
            else if (redir && tgt == m_pc)            m_halt = 1;
            else begin m_pc = tgt; m_cnt = m_cnt + 1; end
        end
    end

    always @(negedge clk) begin
        if (checking) begin
            check("pc",          pc,          m_pc);
            check("imem_addr",   imem_addr,   m_pc);
            check("pc_plus4",    pc_plus4,    m_pc + 32'd4);
            check("instr",       instr,       (m_halt || m_fault) ? NOP : (m_pc ^ MEM_KEY));
            check("halted",      {31'd0, halted},      {31'd0, m_halt});
            check("fetch_fault", {31'd0, fetch_fault}, {31'd0, m_fault});
`ifdef FETCH_PERF_EN
            check("fetch_count", fetch_count, m_cnt);
`else
            check("fetch_count", fetch_count, 32'd0);
`endif
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic idle();
        reset = 0; stall = 0; branch_taken = 0; jump = 0; jump_reg = 0;
        branch_offset = '0; jump_target = '0; reg_target = '0;
    endtask

    task automatic do_reset();
        idle(); reset = 1; step(); reset = 0;
    endtask

    initial begin
        idle();
        reset = 1; step(); step(); reset = 0;
        checking = 1;

        // 1: sequential fetch
        check("rst_pc", pc, 32'h0);
        check("rst_halt", {31'd0, halted}, 32'd0);
        for (int i = 1; i <= 4; i++) begin
            step();
            check("seq_pc", pc, 32'(4 * i));
        end

        // 2: branches backwards and forwards
        branch_taken = 1; branch_offset = 16'hFFFC; step();
        check("br_back", pc, 32'h4);
        branch_offset = 16'h0003; step();
        check("br_fwd", pc, 32'h14);
        idle(); step(); step(); step();
        check("pc_20", pc, 32'h20);

        // 3: jump beats branch, then "j ." halts
        jump = 1; jump_target = 26'h40; branch_taken = 1; branch_offset = 16'h0010; step();
        check("jmp_prio", pc, 32'h100);
        branch_taken = 0; step();
        check("halt_flag", {31'd0, halted}, 32'd1);
        check("halt_pc", pc, 32'h100);
        check("halt_instr", instr, NOP);
        idle(); jump_reg = 1; reg_target = 32'h0000_0200; step(); step();
        check("halt_abs", pc, 32'h100);

        // 4: stall holds a pending jump
        do_reset(); step(); step();
        check("pc_8", pc, 32'h8);
        stall = 1; jump = 1; jump_target = 26'h10;
        for (int i = 0; i < 3; i++) step();
        check("stall_pc", pc, 32'h8);
        stall = 0; step();
        check("stall_rel", pc, 32'h40);

        // 5: misaligned jr faults; jr beats jump
        idle(); jump_reg = 1; reg_target = 32'h0000_0102; step();
        check("fault_flag", {31'd0, fetch_fault}, 32'd1);
        idle();
        for (int i = 0; i < 5; i++) step();
        check("fault_pc", pc, 32'h40);
        check("fault_instr", instr, NOP);
        do_reset();
        check("fault_clr", {31'd0, fetch_fault}, 32'd0);
        check("fault_rpc", pc, RST_PC);
        jump_reg = 1; reg_target = 32'h0000_0200; jump = 1; jump_target = 26'h3; step();
        check("jr_prio", pc, 32'h200);

        // PC wrap via jr to the top word
        idle(); jump_reg = 1; reg_target = 32'hFFFF_FFFC; step();
        check("wrap_p4", pc_plus4, 32'h0);
        idle(); step();
        check("wrap_pc", pc, 32'h0);

        // Reset while stalled
        stall = 1; step(); step(); reset = 1; step(); reset = 0; stall = 0;
        check("rst_stall", pc, RST_PC);

        // 6: 10 advances, 2 stalls, then "j ."
        do_reset();
        for (int i = 0; i < 12; i++) begin
            stall = (i == 3 || i == 7);
            step();
        end
        stall = 0;
        check("adv_pc", pc, 32'h28);
        jump = 1; jump_target = 26'h0A; step(); idle(); step();
        check("end_halt", {31'd0, halted}, 32'd1);
`ifdef FETCH_PERF_EN
        check("end_count", fetch_count, 32'd10);
`else
        check("end_count", fetch_count, 32'd0);
`endif

        @(negedge clk); #1;
        checking = 0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
